// File: rtl/line_window_ctrl.sv
// line_window_ctrl: streams raster pixels into KSIZE+1 rotating line memories
// and presents a KSIZE x KSIZE neighbourhood window per output beat. Both sides
// use ready/valid handshakes; a RELEASE step frees the oldest line per row and
// pulses o_intr.
module line_window_ctrl #(
   parameter  int DATA_W = 8,
   parameter  int IMG_W  = 512,
   parameter  int KSIZE  = 3,
   localparam int NUM_LB = KSIZE + 1,
   localparam int CW     = $clog2(IMG_W),
   localparam int LW     = $clog2(NUM_LB + 1)
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [DATA_W-1:0]                i_pixel_data,
   input  logic                             i_pixel_data_valid,
   output logic                             o_pixel_ready,
   output logic [KSIZE*KSIZE*DATA_W-1:0]    o_pixel_data,
   output logic                             o_pixel_data_valid,
   input  logic                             i_pixel_data_ready,
   output logic [LW-1:0]                    o_lines_full,
   output logic                             o_intr
);

   localparam int LBW = $clog2(NUM_LB);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_READ    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   // line storage, never reset
   logic [DATA_W-1:0]              r_mem [NUM_LB][IMG_W];

   logic [CW-1:0]                  r_wr_col;
   logic [LBW-1:0]                 r_wr_lb;
   logic [CW-1:0]                  r_rd_col;
   logic [LBW-1:0]                 r_rd_lb;
   logic [LW-1:0]                  r_lines_full;
   logic                           r_pixel_ready;
   logic [KSIZE*KSIZE*DATA_W-1:0]  r_pixel_data;
   logic                           r_pixel_data_valid;
   logic                           r_intr;
   state_t                         r_state;

   state_t                         w_state_nxt;
   logic                           w_wr_en;
   logic                           w_line_done;
   logic                           w_load;
   logic                           w_last;
   logic                           w_release;
   logic [LW-1:0]                  w_lines_full_nxt;
   logic [KSIZE*KSIZE*DATA_W-1:0]  w_window;

   assign w_wr_en     = i_pixel_data_valid && r_pixel_ready;
   assign w_line_done = w_wr_en && (r_wr_col == CW'(IMG_W - 1));
   assign w_last      = (r_rd_col == CW'(IMG_W - KSIZE));

   // Window gather: row r comes from line rd_lb+r (mod NUM_LB), columns rd_col..rd_col+KSIZE-1
   for (genvar gr = 0; gr < KSIZE; gr++) begin : g_row
      logic [LBW:0]   w_lb_sum;
      logic [LBW-1:0] w_lb_sel;
      assign w_lb_sum = {1'b0, r_rd_lb} + (LBW+1)'(gr);
      assign w_lb_sel = (w_lb_sum >= (LBW+1)'(NUM_LB)) ?
                        LBW'(w_lb_sum - (LBW+1)'(NUM_LB)) : w_lb_sum[LBW-1:0];
      for (genvar gk = 0; gk < KSIZE; gk++) begin : g_col
         assign w_window[(gr*KSIZE+gk)*DATA_W +: DATA_W] = r_mem[w_lb_sel][r_rd_col + CW'(gk)];
      end
   end

   // Pixel store into the current write line
   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_lb][r_wr_col] <= i_pixel_data;
      end
   end

   // Read FSM next state and per-cycle control
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_lines_full >= LW'(KSIZE)) begin
               w_state_nxt = S_READ;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_READ: begin
            w_load = !r_pixel_data_valid || i_pixel_data_ready;
            if (w_load && w_last) begin
               w_state_nxt = S_RELEASE;
            end else begin
               w_state_nxt = S_READ;
            end
         end
         S_RELEASE: begin
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Line occupancy next value; a simultaneous line completion and release cancel out
   always_comb begin
      w_lines_full_nxt = r_lines_full;
      case ({w_line_done, w_release})
         2'b10:   w_lines_full_nxt = r_lines_full + LW'(1);
         2'b01:   w_lines_full_nxt = r_lines_full - LW'(1);
         default: w_lines_full_nxt = r_lines_full;
      endcase
   end

   // Read FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Write pointers, occupancy count and registered ready flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_col      <= '0;
         r_wr_lb       <= '0;
         r_lines_full  <= '0;
         r_pixel_ready <= 1'b0;
      end else begin
         if (w_wr_en) begin
            if (w_line_done) begin
               r_wr_col <= '0;
               r_wr_lb  <= (r_wr_lb == LBW'(NUM_LB - 1)) ? '0 : r_wr_lb + LBW'(1);
            end else begin
               r_wr_col <= r_wr_col + CW'(1);
            end
         end
         r_lines_full  <= w_lines_full_nxt;
         r_pixel_ready <= (w_lines_full_nxt < LW'(NUM_LB));
      end
   end

   // Read pointers, output window register and row-done interrupt
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_col           <= '0;
         r_rd_lb            <= '0;
         r_pixel_data       <= '0;
         r_pixel_data_valid <= 1'b0;
         r_intr             <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            r_rd_col <= '0;
         end else if (w_load) begin
            r_rd_col <= r_rd_col + CW'(1);
         end
         if (w_release) begin
            r_rd_lb <= (r_rd_lb == LBW'(NUM_LB - 1)) ? '0 : r_rd_lb + LBW'(1);
         end
         if (w_load) begin
            r_pixel_data       <= w_window;
            r_pixel_data_valid <= 1'b1;
         end else if (i_pixel_data_ready) begin
            r_pixel_data_valid <= 1'b0;
         end
         // high exactly during the RELEASE cycle
         r_intr <= w_load && w_last;
      end
   end

   assign o_pixel_ready      = r_pixel_ready;
   assign o_pixel_data       = r_pixel_data;
   assign o_pixel_data_valid = r_pixel_data_valid;
   assign o_lines_full       = r_lines_full;
   assign o_intr             = r_intr;

endmodule

// File: doc/line_window_ctrl.md
Name: line_window_ctrl

Overview:
- Parametrised successor to the 3-line, 512-pixel image line controller.
- Buffers streaming raster pixels in KSIZE+1 rotating line memories and emits a full KSIZE x KSIZE neighbourhood window per output beat for a downstream convolution block.
- Adds ready/valid backpressure on both sides, configurable kernel size, pixel width and image width, a line-occupancy counter and a per-row interrupt.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 512, pixels per image line; must satisfy IMG_W >= KSIZE
KSIZE, 3, window edge length; odd, 1..7
NUM_LB (localparam), KSIZE+1, number of line memories
CW (localparam), $clog2(IMG_W), column counter width
LW (localparam), $clog2(NUM_LB+1), line counter width

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_pixel_data  in  DATA_W  input pixel, raster order
i_pixel_data_valid  in  1  input pixel valid
o_pixel_ready  out  1  block can accept a pixel this cycle
o_pixel_data  out  KSIZE*KSIZE*DATA_W  window; row r (0 = oldest line), column k at bits [(r*KSIZE+k)*DATA_W +: DATA_W]
o_pixel_data_valid  out  1  window valid
i_pixel_data_ready  in  1  downstream accepts window
o_lines_full  out  LW  completed, unreleased lines held
o_intr  out  1  one-cycle pulse when an output row has been fully emitted

Behaviour:
Reset:
- Asynchronous reset while i_rst_n = 0 clears all pointers, counters, FSM state and outputs.
- o_pixel_data = 0, o_pixel_data_valid = 0, o_intr = 0, o_lines_full = 0, o_pixel_ready = 1 one cycle after release.
- Memory contents are not cleared.
- Reset mid-row discards all partial and complete lines.

Write side:
- o_pixel_ready = (lines_full < NUM_LB).
- A pixel is written only when i_pixel_data_valid && o_pixel_ready. It goes to wr_lb[wr_col], and wr_col increments.
- When wr_col == IMG_W-1 on a write: wr_col wraps to 0, wr_lb advances modulo NUM_LB, and lines_full increments.
- A pixel presented while o_pixel_ready = 0 is not written and is not counted; the source must hold it.

Read FSM: IDLE, READ, RELEASE.
- IDLE: when lines_full >= KSIZE, go to READ with rd_col = 0.
- READ: the output register loads when !o_pixel_data_valid || i_pixel_data_ready.
  - Load value: window rows = lines rd_lb, rd_lb+1, ..., rd_lb+KSIZE-1 (mod NUM_LB), columns rd_col .. rd_col+KSIZE-1.
  - On load, o_pixel_data_valid <= 1 and rd_col increments.
  - After the load of rd_col = IMG_W-KSIZE, go to RELEASE.
  - If there is no load and the held beat is accepted, o_pixel_data_valid <= 0.
- Output register hold rule: while o_pixel_data_valid && !i_pixel_data_ready, o_pixel_data and o_pixel_data_valid hold stable.
- Beat count: exactly IMG_W-KSIZE+1 beats per row; no edge padding.
- RELEASE (one cycle):
  - rd_lb advances modulo NUM_LB and lines_full decrements.
  - o_intr = 1 for this cycle only.
  - Return to IDLE. The last beat may still be pending in the output register; this is allowed.
- Simultaneous write-line-complete and RELEASE in the same cycle: lines_full is unchanged.
- The released line memory is immediately writable in the next cycle.
- Latency: first window valid 2 cycles after the cycle that completes line KSIZE (IDLE detect, then load).
- Throughput: with i_pixel_data_ready held at 1, one window per cycle in READ. Row overhead is 2 cycles (RELEASE + IDLE).
- o_lines_full = lines_full, registered. Range is 0..NUM_LB; it never over- or underflows.

Test Plan:
- IMG_W=8, KSIZE=3, pixel value = 8*row+col, continuous valid, ready=1 -> first window after 24 pixels is rows 0-2 cols 0-2 (bytes 0,1,2,8,9,10,16,17,18 in ascending field order); 6 beats per row; o_intr pulses after beat 6.
- Same config, i_pixel_data_ready held 0 after first beat for 10 cycles -> o_pixel_data stable and valid stays 1; no beat lost or duplicated; 6 total beats per row.
- Sink stalled permanently, 40 pixels offered -> o_pixel_ready drops after 32 pixels (lines_full = 4); pixels 33-40 are not written; after stall release the pixel stream resumes in order.
- Write completes line 4 in the same cycle as RELEASE of row 0 -> o_lines_full stays 3; the next row's windows start at line 1.
- Assert i_rst_n = 0 mid-READ (rd_col = 3) -> all outputs 0 asynchronously; a fresh 3-line feed reproduces the first-row windows exactly.
- Defaults (512, KSIZE=3, DATA_W=8) plus KSIZE=5 with IMG_W=16, full 20-line frame -> (512-2) and (16-4) beats per row; window contents match a reference model; o_intr count = lines-KSIZE+1.
